// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches a program from a synchronous ROM and drives a processor's
// Run/DIN/Done handshake, supplying mvi immediates and halting on end, Stop or timeout.
`default_nettype none

module instr_sequencer #(
  parameter int          DATA_W   = 9,
  parameter int          ADDR_W   = 5,
  parameter int          PROG_LEN = 32,
  parameter logic [2:0]  MVI_OP   = 3'b001,
  parameter int          TIMEOUT  = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] din_o,
  output logic              run_o,
  input  logic              done_i,
  output logic              busy_o,
  output logic              halted_o,
  output logic              error_o,
  output logic [7:0]        instr_count_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e              state_q;
  logic [ADDR_W:0]     pc_q;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   imm_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                run_q;
  logic                busy_q;
  logic                halted_q;
  logic                error_q;
  logic [7:0]          count_q;

  logic                is_mvi_d;
  logic [ADDR_W:0]     pc_d;

  // PC is one bit wider than the ROM address so the end-of-program compare never wraps.
  assign is_mvi_d = (op_q == MVI_OP);
  assign pc_d     = pc_q + (is_mvi_d ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      op_q       <= '0;
      imm_q      <= '0;
      wait_cnt_q <= '0;
      mem_addr_q <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      run_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start_i) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            count_q    <= '0;
            error_q    <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        S_FETCH: begin
          state_q    <= S_ISSUE;
          run_q      <= 1'b1;
          mem_addr_q <= pc_q[ADDR_W-1:0] + 1'b1;
        end
        S_ISSUE: begin
          state_q    <= S_WAIT;
          op_q       <= mem_data_i[DATA_W-1 -: 3];
          wait_cnt_q <= '0;
        end
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          if (wait_cnt_q == '0) imm_q <= mem_data_i;
          if (done_i) begin
            pc_q       <= pc_d;
            mem_addr_q <= pc_d[ADDR_W-1:0];
            if (count_q != 8'hFF) count_q <= count_q + 1'b1;
            if (pc_d >= (ADDR_W+1)'(PROG_LEN) || stop_i) begin
              state_q  <= S_HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              state_q  <= S_FETCH;
            end
          end else if (wait_cnt_q == CNT_W'(TIMEOUT-1)) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            error_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The immediate comes straight from the ROM in the first WAIT cycle, then from its capture.
  always_comb begin
    din_o = '0;
    if (state_q == S_ISSUE) begin
      din_o = mem_data_i;
    end else if (state_q == S_WAIT && is_mvi_d) begin
      din_o = (wait_cnt_q == '0) ? mem_data_i : imm_q;
    end
  end

  assign mem_addr_o    = mem_addr_q;
  assign run_o         = run_q;
  assign busy_o        = busy_q;
  assign halted_o      = halted_q;
  assign error_o       = error_q;
  assign instr_count_o = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: small ROM model, auto Done responder, hand-computed checks.
`default_nettype none

module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop;
  logic [1:0] mem_addr;
  logic [8:0] rdata, din;
  logic       run, done, busy, halted, error;
  logic [7:0] icount;

  logic       done_r = 1'b0;
  logic       force_done;
  int         done_lat;
  int         run_total = 0;
  int         n_checks = 0;
  int         n_err = 0;
  logic [8:0] rom [4];

  always #5 clk = ~clk;
  always @(posedge clk) rdata <= rom[mem_addr];
  assign done = done_r | force_done;

  instr_sequencer #(
    .DATA_W(9), .ADDR_W(2), .PROG_LEN(4), .MVI_OP(3'b001), .TIMEOUT(64)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
    .mem_addr_o(mem_addr), .mem_data_i(rdata), .din_o(din), .run_o(run),
    .done_i(done), .busy_o(busy), .halted_o(halted), .error_o(error),
    .instr_count_o(icount)
  );

  // Processor stand-in: answers each Run with Done done_lat cycles later (0 = never).
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        run_total++;
        if (done_lat > 0) begin
          repeat (done_lat) @(posedge clk);
          #1 done_r = 1'b1;
          @(posedge clk);
          #1 done_r = 1'b0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int max);
    int n = 0;
    while (!halted && n < max) begin
      cyc();
      n++;
    end
    check_eq("halt_wait", 32'(halted), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; force_done = 1'b0; done_lat = 1;
    for (int i = 0; i < 4; i++) rom[i] = 9'o001;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_addr",   32'(mem_addr), 0);
    check_eq("rst_din",    32'(din),      0);
    check_eq("rst_run",    32'(run),      0);
    check_eq("rst_busy",   32'(busy),     0);
    check_eq("rst_halted", 32'(halted),   0);
    check_eq("rst_error",  32'(error),    0);
    check_eq("rst_count",  32'(icount),   0);
    rst_n = 1'b1;
    cyc();

    stop = 1'b1;
    cyc(); cyc();
    check_eq("idle_stop_halted", 32'(halted), 0);
    check_eq("idle_stop_busy",   32'(busy),   0);
    stop = 1'b0;

    // Single mv: Run in cycle 2, Start during WAIT ignored.
    start_run();
    check_eq("t1_fetch_run",  32'(run),      0);
    check_eq("t1_fetch_addr", 32'(mem_addr), 0);
    check_eq("t1_fetch_busy", 32'(busy),     1);
    cyc();
    check_eq("t1_issue_run",  32'(run),      1);
    check_eq("t1_issue_din",  32'(din),      9'o001);
    cyc();
    check_eq("t1_wait_run",   32'(run),      0);
    check_eq("t1_wait_din",   32'(din),      0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_eq("t1_next_addr",  32'(mem_addr), 1);
    check_eq("t1_count",      32'(icount),   1);
    wait_halt(40);
    check_eq("t1_final_count", 32'(icount),  4);

    // mvi with immediate held through a 3-cycle WAIT.
    rom[0] = 9'o100; rom[1] = 9'd6; rom[2] = 9'o001; rom[3] = 9'o001;
    done_lat = 3;
    start_run();
    check_eq("t2_restart_count", 32'(icount), 0);
    cyc();
    check_eq("t2_issue_din", 32'(din), 9'o100);
    cyc();
    check_eq("t2_wait1_din", 32'(din), 6);
    cyc();
    check_eq("t2_wait2_din", 32'(din), 6);
    cyc();
    check_eq("t2_wait3_din", 32'(din), 6);
    cyc();
    check_eq("t2_next_addr", 32'(mem_addr), 2);
    check_eq("t2_fetch_din", 32'(din),      0);
    check_eq("t2_count",     32'(icount),   1);
    wait_halt(40);
    check_eq("t2_final_count", 32'(icount), 3);

    // Four mv words, 3 cycles each -> HALT visible in cycle 13.
    for (int i = 0; i < 4; i++) rom[i] = 9'o001;
    done_lat = 1;
    base = run_total;
    start_run();
    repeat (11) cyc();
    check_eq("t3_c12_halted", 32'(halted), 0);
    cyc();
    check_eq("t3_c13_halted", 32'(halted), 1);
    check_eq("t3_count",      32'(icount), 4);
    check_eq("t3_runs",       32'(run_total - base), 4);
    check_eq("t3_error",      32'(error),  0);

    // mvi at the last PC: immediate from wrapped address 0, clean halt.
    rom[0] = 9'o002; rom[3] = 9'o100;
    start_run();
    repeat (11) cyc();
    check_eq("tb_wrap_addr", 32'(mem_addr), 0);
    check_eq("tb_wrap_din",  32'(din),      9'o002);
    cyc();
    check_eq("tb_halted", 32'(halted), 1);
    check_eq("tb_error",  32'(error),  0);
    check_eq("tb_count",  32'(icount), 4);

    // Done never arrives: timeout on WAIT cycle 64.
    rom[0] = 9'o001; rom[3] = 9'o001;
    done_lat = 0;
    start_run();
    repeat (65) cyc();
    check_eq("t4_c66_halted", 32'(halted), 0);
    check_eq("t4_c66_busy",   32'(busy),   1);
    cyc();
    check_eq("t4_halted", 32'(halted), 1);
    check_eq("t4_error",  32'(error),  1);
    check_eq("t4_count",  32'(icount), 0);
    done_lat = 1;
    start_run();
    check_eq("t4_err_clear", 32'(error),    0);
    check_eq("t4_pc0",       32'(mem_addr), 0);
    wait_halt(40);
    check_eq("t4_rerun_count", 32'(icount), 4);

    // Stop during WAIT of instruction 2 takes effect at its Done.
    done_lat = 3;
    base = run_total;
    start_run();
    for (int n = 0; n < 20 && (run_total - base) < 2; n++) cyc();
    check_eq("t5_second_run", 32'(run_total - base), 2);
    stop = 1'b1;
    cyc();
    check_eq("t5_not_aborted", 32'(busy), 1);
    wait_halt(10);
    check_eq("t5_count", 32'(icount), 2);
    repeat (4) cyc();
    check_eq("t5_runs", 32'(run_total - base), 2);
    stop = 1'b0;

    // Async reset in WAIT of an mvi clears outputs immediately; later Done ignored.
    rom[0] = 9'o100; rom[1] = 9'd6;
    done_lat = 0;
    start_run();
    cyc(); cyc();
    check_eq("t6_wait_din",  32'(din),  6);
    check_eq("t6_wait_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_din",  32'(din),  0);
    check_eq("t6_rst_run",  32'(run),  0);
    check_eq("t6_rst_busy", 32'(busy), 0);
    cyc();
    rst_n = 1'b1;
    force_done = 1'b1;
    cyc(); cyc();
    force_done = 1'b0;
    check_eq("t6_count",  32'(icount),   0);
    check_eq("t6_busy",   32'(busy),     0);
    check_eq("t6_halted", 32'(halted),   0);
    check_eq("t6_addr",   32'(mem_addr), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
